ws2812_decoder: RTL
===================

# ws2812_decoder

Receive-side counterpart of the WS2812 output path. It recovers pixel data from an already-synchronised WS2812 line by measuring each high-pulse width and each low gap. It assembles 24-bit GRB words and presents them on a valid/ready interface. It also reports frame boundaries (reset/latch gaps) and protocol errors to the upstream pipeline.

## Interface
Parameters:
- CNT_WIDTH, 13, width of the shared pulse counter; saturates at all-ones; must satisfy 2^CNT_WIDTH-1 >= RESET_CYCLES
- MIN_HIGH_CYCLES, 10, high pulses shorter than this are glitches
- BIT_THRESH_CYCLES, 60, high width <= this decodes as 0, above it decodes as 1
- MAX_HIGH_CYCLES, 120, high width above this is an error
- RESET_CYCLES, 5000, low duration that marks frame end (50 us at 100 MHz)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_signal  in  1  synchronised WS2812 line
- o_pixel_data  out  24  decoded GRB word, MSB = first received bit
- o_pixel_valid  out  1  o_pixel_data holds an unconsumed pixel
- i_pixel_ready  in  1  consumer accepts the pixel when valid && ready
- o_frame_end  out  1  one-cycle pulse when a reset gap is detected
- o_bit_error  out  1  one-cycle pulse on glitch, overlong high, or partial pixel at frame end
- o_overflow  out  1  sticky; set when a pixel completes while o_pixel_valid=1 and i_pixel_ready=0; cleared only by reset

## Operation
- State machine: S_SYNC, S_IDLE, S_HIGH, S_LOW. Reset state is S_SYNC.
- S_SYNC
  - Counts consecutive low samples; any high sample clears the count.
  - Count reaching RESET_CYCLES -> S_IDLE (no o_frame_end).
- S_IDLE
  - First high sample -> S_HIGH with counter=1 and bit counter unchanged.
- S_HIGH
  - Counter increments each high sample.
  - Counter exceeding MAX_HIGH_CYCLES while still high -> o_bit_error pulse, bit counter cleared, -> S_SYNC.
  - On first low sample, classify the count:
    - count < MIN_HIGH_CYCLES: o_bit_error, no shift.
    - count <= BIT_THRESH_CYCLES: shift in 0.
    - otherwise shift in 1.
  - Then -> S_LOW with counter=1.
- S_LOW
  - Counter increments each low sample.
  - First high sample -> S_HIGH with counter=1.
  - Counter reaching RESET_CYCLES -> o_frame_end pulse -> S_IDLE.
  - If the bit counter is nonzero at that point: o_bit_error pulses in the same cycle, and the bit counter and shift register clear.
- Bits shift into a 24-bit register MSB-first. The bit counter runs 0..23.
- On the 24th bit, the complete word (including the new bit) loads into o_pixel_data, o_pixel_valid sets, and the bit counter wraps to 0.
- Handshake
  - o_pixel_valid and o_pixel_data hold stable until valid && ready.
  - Valid clears the cycle after acceptance.
  - If a new pixel completes in the same cycle as acceptance, it is loaded and valid stays 1 (no overflow).
  - If a new pixel completes while valid=1 and ready=0, the new pixel is dropped, the held data is kept, and o_overflow sets.
- Counter arithmetic
  - Unsigned, saturating at 2^CNT_WIDTH-1.
  - Clears on every state transition.

## Timing
- Reset values: o_pixel_data=0, o_pixel_valid=0, o_frame_end=0, o_bit_error=0, o_overflow=0, state S_SYNC, counters 0.
- Reset asserted mid-pixel discards partial bits immediately.
- All outputs are registered.
- Bit decode latency: 1 cycle. The shift occurs at the clock edge sampling the first low.
- Pixel latency: o_pixel_valid is high starting the cycle after the edge that samples the first low following the 24th high pulse.
- o_frame_end is high for exactly the cycle after the edge at which the low count reaches RESET_CYCLES.
- Decode is bounded by pulse width only; the low-gap width within a frame is not checked (below RESET_CYCLES).
- Simultaneous o_frame_end and o_bit_error is legal (partial pixel case).

## Configuration
- WS2812_DECODER_GLITCH_FILTER_EN defined: i_signal passes through a 3-sample shift register with majority vote before the state machine.
  - Adds 2 cycles latency to every edge and to all outputs.
  - Single-cycle spikes are suppressed without o_bit_error.
- Not defined: the state machine uses i_signal directly.
  - A 1-cycle spike in S_IDLE/S_LOW produces an o_bit_error glitch pulse.

## Test plan
- Reset; hold low 5000 cycles; send 24 bits of 0xA53CF0 (0 = 40 high / 85 low, 1 = 80 high / 45 low) -> o_pixel_valid rises 1 cycle after the final falling edge with o_pixel_data=0xA53CF0.
- Same pixel, ready held low, second pixel 0x123456 follows -> data stays 0xA53CF0 and o_overflow=1. Raising ready then clears valid the next cycle.
- 12 valid bits then 5000 low cycles -> o_frame_end and o_bit_error pulse together; the next 24 bits of 0xFFFFFF decode correctly.
- High pulse of 121 cycles -> o_bit_error at cycle 121 of high; no pixel until a 5000-cycle low resync.
- 3-cycle high spike between bits -> o_bit_error, bit count unchanged. With WS2812_DECODER_GLITCH_FILTER_EN, a 1-cycle spike is ignored silently.
- Assert i_reset_n low after 10 bits -> all outputs 0; a full pixel after resync decodes cleanly.

Source files
------------

// File: rtl/ws2812_decoder.sv
// WS2812 receive decoder: times high pulses and low gaps on a synchronised line,
// assembles 24-bit GRB words and reports frame ends and protocol errors.
// Optional WS2812_DECODER_GLITCH_FILTER_EN inserts a 3-sample majority filter on the line.
module ws2812_decoder #(
  parameter int CNT_WIDTH         = 13,
  parameter int MIN_HIGH_CYCLES   = 10,
  parameter int BIT_THRESH_CYCLES = 60,
  parameter int MAX_HIGH_CYCLES   = 120,
  parameter int RESET_CYCLES      = 5000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_signal,
  output logic [23:0] o_pixel_data,
  output logic        o_pixel_valid,
  input  logic        i_pixel_ready,
  output logic        o_frame_end,
  output logic        o_bit_error,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  // Whole control state in one struct so the FSM, counters and partial word can be probed together.
  typedef struct packed {
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [4:0]             bit_cnt;
    logic [23:0]            shreg;
  } ctrl_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_C    = CNT_WIDTH'(MIN_HIGH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] THRESH_C = CNT_WIDTH'(BIT_THRESH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_HIGH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RESET_C  = CNT_WIDTH'(RESET_CYCLES);

  logic line;

`ifdef WS2812_DECODER_GLITCH_FILTER_EN
  logic [2:0] taps;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      taps <= '0;
    end else begin
      taps <= {taps[1:0], i_signal};
    end
  end

  assign line = (taps[0] & taps[1]) | (taps[1] & taps[2]) | (taps[0] & taps[2]);
`else
  assign line = i_signal;
`endif

  ctrl_t                cur;
  ctrl_t                nxt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 shift_en;
  logic                 shift_bit;
  logic                 err_d;
  logic                 fe_d;
  logic                 pixel_done;
  logic [23:0]          word;

  assign cnt_inc = (cur.cnt == CNT_MAX) ? cur.cnt : cur.cnt + 1'b1;

  always_comb begin
    nxt       = cur;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    err_d     = 1'b0;
    fe_d      = 1'b0;

    case (cur.state)
      S_SYNC: begin
        if (line) begin
          nxt.cnt = '0;
        end else if (cnt_inc >= RESET_C) begin
          nxt.state = S_IDLE;
          nxt.cnt   = '0;
        end else begin
          nxt.cnt = cnt_inc;
        end
      end

      S_IDLE: begin
        if (line) begin
          nxt.state = S_HIGH;
          nxt.cnt   = CNT_ONE;
        end
      end

      S_HIGH: begin
        if (line) begin
          if (cnt_inc > MAX_C) begin
            err_d       = 1'b1;
            nxt.state   = S_SYNC;
            nxt.cnt     = '0;
            nxt.bit_cnt = '0;
            nxt.shreg   = '0;
          end else begin
            nxt.cnt = cnt_inc;
          end
        end else begin
          // Falling edge: the count holds the full high width.
          if (cur.cnt < MIN_C) begin
            err_d = 1'b1;
          end else begin
            shift_en  = 1'b1;
            shift_bit = (cur.cnt > THRESH_C);
          end
          nxt.state = S_LOW;
          nxt.cnt   = CNT_ONE;
        end
      end

      S_LOW: begin
        if (line) begin
          nxt.state = S_HIGH;
          nxt.cnt   = CNT_ONE;
        end else if (cnt_inc >= RESET_C) begin
          fe_d      = 1'b1;
          nxt.state = S_IDLE;
          nxt.cnt   = '0;
          if (cur.bit_cnt != 5'd0) begin
            err_d       = 1'b1;
            nxt.bit_cnt = '0;
            nxt.shreg   = '0;
          end
        end else begin
          nxt.cnt = cnt_inc;
        end
      end

      default: begin
        nxt.state   = S_SYNC;
        nxt.cnt     = '0;
        nxt.bit_cnt = '0;
        nxt.shreg   = '0;
      end
    endcase

    if (shift_en) begin
      nxt.shreg = {cur.shreg[22:0], shift_bit};
      if (cur.bit_cnt == 5'd23) begin
        nxt.bit_cnt = '0;
      end else begin
        nxt.bit_cnt = cur.bit_cnt + 5'd1;
      end
    end
  end

  assign pixel_done = shift_en && (cur.bit_cnt == 5'd23);
  assign word       = {cur.shreg[22:0], shift_bit};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cur.state   <= S_SYNC;
      cur.cnt     <= '0;
      cur.bit_cnt <= '0;
      cur.shreg   <= '0;
    end else begin
      cur <= nxt;
    end
  end

  // Pixel handshake: o_pixel_data/o_pixel_valid hold until valid && ready at a clock
  // edge; a pixel completing on that same edge replaces the accepted one, while a
  // pixel completing against a stalled consumer is dropped and flagged in o_overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_end   <= 1'b0;
      o_bit_error   <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_frame_end <= fe_d;
      o_bit_error <= err_d;
      if (pixel_done && (!o_pixel_valid || i_pixel_ready)) begin
        o_pixel_data  <= word;
        o_pixel_valid <= 1'b1;
      end else if (pixel_done) begin
        o_overflow <= 1'b1;
      end else if (o_pixel_valid && i_pixel_ready) begin
        o_pixel_valid <= 1'b0;
      end
    end
  end

endmodule
